// File: rtl/ifetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_prefetch_queue
// Purpose  : Prefetch queue between a multi-cycle instruction memory and the
//            IF/ID register. Issues sequential word fetches ahead of the
//            pipeline, buffers {pc, instruction} pairs in a circular FIFO and
//            presents the oldest pair with a valid/ready handshake. A redirect
//            flushes buffered and in-flight instructions and restarts fetching
//            at the target.
// Ports    : clk_i, rst_n_i (sync, active-low)
//            redirect_i, redirect_pc_i        - flush / restart request
//            mem_req_o, mem_addr_o            - fetch request to memory
//            mem_ack_i, mem_data_i            - memory response
//            inst_valid_o, inst_ready_i       - head-entry handshake
//            inst_pc_o, inst_o                - head entry
//            count_o                          - number of buffered entries
// Options  : IFETCH_BYPASS_EN - when defined, an ack arriving while the FIFO
//            is empty is presented on the output in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_data_i,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [31:0]              inst_pc_o,
  output logic [31:0]              inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [31:0]     fetch_pc;
  logic [31:0]     hold_addr;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic [31:0]     pc_buf   [DEPTH];
  logic [31:0]     inst_buf [DEPTH];

  logic            ack_take;
  logic            bypass_hit;
  logic            push;
  logic            fifo_pop;

  // Datapath control: redirect outranks both push and pop.
  always_comb begin
    ack_take = (state == WAIT) && mem_ack_i && !redirect_i;
`ifdef IFETCH_BYPASS_EN
    bypass_hit = ack_take && (count == '0);
`else
    bypass_hit = 1'b0;
`endif
    inst_valid_o = (count != '0) || bypass_hit;
    inst_o       = bypass_hit ? mem_data_i : inst_buf[rd_ptr];
    inst_pc_o    = bypass_hit ? fetch_pc   : pc_buf[rd_ptr];
    fifo_pop     = (count != '0) && inst_ready_i && !redirect_i;
    // A bypassed word that is accepted immediately never enters the FIFO.
    push         = ack_take && !(bypass_hit && inst_ready_i);
    if (redirect_i) begin
      count_next = '0;
    end else begin
      count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, fifo_pop};
    end
  end

  // Next-state and memory-request outputs.
  always_comb begin
    state_next = state;
    mem_req_o  = 1'b0;
    mem_addr_o = fetch_pc;
    case (state)
      IDLE: begin
        if (!redirect_i && (count < FULL)) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        mem_req_o = 1'b1;
        if (redirect_i) begin
          // A same-cycle ack completes the old request; otherwise its
          // response is still owed and must be swallowed.
          state_next = mem_ack_i ? IDLE : DISCARD;
        end else if (mem_ack_i) begin
          state_next = (count_next < FULL) ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        // fetch_pc already holds the new target; keep the old address
        // on the bus until the abandoned request is acknowledged.
        mem_req_o  = 1'b1;
        mem_addr_o = hold_addr;
        if (mem_ack_i) begin
          state_next = (!redirect_i && (count_next < FULL)) ? WAIT : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (ack_take) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (fifo_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // Storage and the in-flight address copy need no reset.
  always_ff @(posedge clk_i) begin
    if (state != DISCARD) begin
      hold_addr <= fetch_pc;
    end
    if (push) begin
      pc_buf[wr_ptr]   <= fetch_pc;
      inst_buf[wr_ptr] <= mem_data_i;
    end
  end

  assign count_o = count;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_prefetch_queue
// Purpose  : Self-checking bench for ifetch_prefetch_queue. A driver applies
//            directed stimulus and queues expected instructions and probe
//            values; a separate monitor compares them against the DUT.
//            Honours IFETCH_BYPASS_EN for the same-cycle bypass check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch_queue;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_ack;
  logic [31:0]            mem_data;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [31:0]            inst_pc;
  logic [31:0]            inst;
  logic [$clog2(DEPTH):0] count;

  ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_data),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .inst_pc_o    (inst_pc),
    .inst_o       (inst),
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } pair_t;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    logic [31:0] aux;
  } probe_t;

  pair_t  exp_q[$];
  probe_t probe_q[$];
  int     compared   = 0;
  int     mismatched = 0;

  // Memory contents: every word is its address xor a fixed pattern.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h00A0_0093;
  endfunction

  function automatic string pname(input int sel);
    case (sel)
      0: return "count";
      1: return "inst_valid";
      2: return "mem_req";
      3: return "mem_addr";
      4: return "inst";
      5: return "inst_pc";
      6: return "sb_leftover";
      default: return "timeout";
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] act;
    probe_t      p;
    pair_t       e;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      case (p.sel)
        0: act = 32'(count);
        1: act = {31'b0, inst_valid};
        2: act = {31'b0, mem_req};
        3: act = mem_addr;
        4: act = inst;
        5: act = inst_pc;
        6: act = 32'(exp_q.size());
        default: act = p.aux;
      endcase
      compared++;
      if (act !== p.exp) begin
        mismatched++;
        $display("FAIL %s: got %h expected %h (t=%0t)", pname(p.sel), act, p.exp, $time);
      end
    end
    if (rst_n && inst_valid && inst_ready && !redirect) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_inst: got pc=%h inst=%h expected none", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst !== e.ins) begin
          mismatched++;
          $display("FAIL delivered: got pc=%h inst=%h expected pc=%h inst=%h",
                   inst_pc, inst, e.pc, e.ins);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int sel, input logic [31:0] exp);
    probe_t p;
    p.sel = sel; p.exp = exp; p.aux = 32'd0;
    probe_q.push_back(p);
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] ins);
    pair_t e;
    e.pc = pc; e.ins = ins;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    mem_ack = 1'b0;
    repeat (n) step();
  endtask

  // Acknowledge n requests, each after lat cycles of mem_req, checking that
  // the addresses run sequentially from first.
  task automatic serve(input int n, input int lat, input logic [31:0] first);
    int          got    = 0;
    int          w      = 0;
    int          budget = 200;
    logic [31:0] a      = first;
    probe_t      p;
    while (got < n && budget > 0) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        w++;
        if (w >= lat) begin
          mem_ack  = 1'b1;
          mem_data = memf(mem_addr);
          probe(3, a);
          a   = a + 32'd4;
          w   = 0;
          got++;
        end
      end
      step();
      budget--;
    end
    mem_ack = 1'b0;
    if (got < n) begin
      p.sel = 7; p.exp = 32'd0; p.aux = 32'd1;
      probe_q.push_back(p);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    mem_ack = 1'b0; mem_data = 32'd0; inst_ready = 1'b1;
    #1;
    repeat (2) step();
    probe(0, 0); probe(1, 0); probe(2, 0);
    rst_n = 1'b1;

    // Sequential fetch with single-cycle acks.
    expect_inst(32'h0, 32'h00A0_0093);
    expect_inst(32'h4, 32'h00A0_0097);
    expect_inst(32'h8, 32'h00A0_009B);
    expect_inst(32'hC, 32'h00A0_009F);
    serve(4, 1, 32'h0);
    idle(3);
    probe(0, 0); probe(2, 1); probe(3, 32'h10);

    // Reset in the middle of a WAIT.
    rst_n = 1'b0;
    step();
    probe(2, 0); probe(0, 0);
    rst_n = 1'b1;

    // Stalled consumer fills the FIFO, then fetching resumes at 0x10.
    inst_ready = 1'b0;
    expect_inst(32'h0, 32'h00A0_0093);
    expect_inst(32'h4, 32'h00A0_0097);
    expect_inst(32'h8, 32'h00A0_009B);
    expect_inst(32'hC, 32'h00A0_009F);
    serve(4, 1, 32'h0);
    idle(3);
    probe(0, 4); probe(2, 0); probe(1, 1); probe(5, 32'h0); probe(4, 32'h00A0_0093);
    inst_ready = 1'b1;
    expect_inst(32'h10, 32'h00A0_0083);
    serve(1, 1, 32'h10);
    idle(3);

    // Refill, pop one entry, then redirect with count=3 and nothing in flight.
    inst_ready = 1'b0;
    expect_inst(32'h14, 32'h00A0_0087);
    serve(4, 1, 32'h14);
    idle(1);
    inst_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    probe(0, 3); probe(2, 0);
    step();
    redirect = 1'b0;
    probe(0, 0); probe(1, 0);
    expect_inst(32'h100, 32'h00A0_0193);
    serve(1, 1, 32'h100);
    idle(1);

    // Redirect while waiting on 0x8; the ack arrives three cycles later.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_inst(32'h0, 32'h00A0_0093);
    expect_inst(32'h4, 32'h00A0_0097);
    serve(2, 1, 32'h0);
    idle(1);
    probe(2, 1); probe(3, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    repeat (2) begin
      probe(2, 1); probe(3, 32'h8);
      step();
    end
    mem_ack = 1'b1; mem_data = 32'h00A0_009B;
    probe(3, 32'h8);
    step();
    mem_ack = 1'b0;
    probe(2, 1); probe(3, 32'h200); probe(0, 0);
    expect_inst(32'h200, 32'h00A0_0293);
    serve(1, 1, 32'h200);
    idle(1);

    // Redirect and ack in the same cycle.
    probe(3, 32'h204);
    mem_ack = 1'b1; mem_data = 32'h00A0_0297;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    mem_ack = 1'b0; redirect = 1'b0;
    probe(0, 0); probe(2, 0); probe(1, 0);
    expect_inst(32'h300, 32'h00A0_0393);
    serve(1, 1, 32'h300);
    idle(2);
    probe(0, 0);

    // Empty FIFO, consumer ready, ack of the first word after reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    probe(2, 1); probe(3, 32'h0);
    mem_ack = 1'b1; mem_data = 32'h00A0_0093;
    expect_inst(32'h0, 32'h00A0_0093);
`ifdef IFETCH_BYPASS_EN
    probe(1, 1); probe(4, 32'h00A0_0093); probe(5, 32'h0);
    step();
    mem_ack = 1'b0;
    probe(0, 0);
`else
    probe(1, 0);
    step();
    mem_ack = 1'b0;
    probe(0, 1); probe(1, 1); probe(4, 32'h00A0_0093); probe(5, 32'h0);
`endif
    idle(3);
    probe(6, 0);
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
